// File: rtl/s4ga_stream.sv
// s4ga_stream: serially configured K-LUT overlay with a stallable config stream.
// Each accepted beat shifts the N-bit history; a mask-final beat evaluates one LUT
// into it, and the last LUT of a frame also updates pins_out.
module s4ga_stream #(
  parameter int unsigned N    = 71,
  parameter int unsigned K    = 5,
  parameter int unsigned I    = 4,
  parameter int unsigned O    = 8,
  parameter int unsigned SI_W = 4,
  parameter int unsigned FC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SI_W-1:0] si,
  input  logic            si_valid,
  input  logic [I-1:0]    pins_in,
  output logic [O-1:0]    pins_out,
  output logic            out_valid,
  output logic [FC_W-1:0] frames,
  output logic            debug
);

  localparam int unsigned N_W       = $clog2(N);
  localparam int unsigned SEL_W     = 1 << N_W;
  localparam int unsigned M         = 1 << K;
  localparam int unsigned IDX_SEGS  = (N_W + SI_W - 1) / SI_W;
  localparam int unsigned MASK_SEGS = (M + SI_W - 1) / SI_W;
  localparam int unsigned LL        = K * IDX_SEGS + MASK_SEGS;
  localparam int unsigned MAX_SEGS  = (IDX_SEGS > MASK_SEGS) ? IDX_SEGS : MASK_SEGS;
  localparam int unsigned IDX_W     = IDX_SEGS * SI_W;
  localparam int unsigned ACC_W     = ((MAX_SEGS > 1) ? (MAX_SEGS - 1) : 1) * SI_W;
  localparam int unsigned CUR_W     = ACC_W + SI_W;
  localparam int unsigned K_CW      = $clog2(K + 1);
  localparam int unsigned SEG_W     = $clog2(MAX_SEGS + 1);

  logic [N_W-1:0]   n;
  logic [K_CW-1:0]  k;
  logic [SEG_W-1:0] seg;
  logic [ACC_W-1:0] acc;
  logic [K-1:0]     ins;
  logic             q;
  logic [N-1:0]     hist;
  logic [I-1:0]     smp;

  logic [CUR_W-1:0] cur;
  logic [IDX_W-1:0] idx;
  logic [M-1:0]     lut_mask;
  logic             idx_phase;
  logic             last_seg;
  logic             frame_start;
  logic             mask_final;
  logic             frame_end;
  logic [I-1:0]     smp_eff;
  logic [SEL_W-1:0] sel_vec;
  logic             in_bit;
  logic             lut;
  logic             half;
  logic             b;
  logic [O-1:0]     tap;

  // Beat classification and field assembly (current segment appended LS)
  always_comb begin
    cur         = {acc, si};
    idx         = cur[IDX_W-1:0];
    lut_mask    = cur[M-1:0];
    idx_phase   = (k != K_CW'(K));
    last_seg    = idx_phase ? (seg == SEG_W'(IDX_SEGS - 1)) : (seg == SEG_W'(MASK_SEGS - 1));
    frame_start = (n == '0) && (k == '0) && (seg == '0);
    mask_final  = !idx_phase && last_seg;
    frame_end   = mask_final && (n == N_W'(N - 1));
  end

  // Index decode; the frame's first beat sees pins_in before it lands in smp
  always_comb begin
    smp_eff          = frame_start ? pins_in : smp;
    sel_vec          = '0;
    sel_vec[N-1:0]   = hist;
    sel_vec[N+I-1:N] = smp_eff;
    sel_vec[SEL_W-3] = q;
    sel_vec[SEL_W-2] = 1'b0;
    sel_vec[SEL_W-1] = 1'b1;
    in_bit           = ((idx >> N_W) == '0) ? sel_vec[idx[N_W-1:0]] : 1'b0;
  end

  // LUT evaluation, half-LUT for q, and the bit shifted into the history
  always_comb begin
    lut  = lut_mask[ins];
    half = lut_mask[{1'b0, ins[K-2:0]}];
    b    = mask_final ? lut : hist[N-1];
  end

  // pins_out[j] is LUT N-1-j; it entered hist LL*j beats ago and has rotated since
  assign tap[0] = lut;
  for (genvar j = 1; j < O; j++) begin : g_tap
    assign tap[j] = hist[(LL * j - 1) % N];
  end

  // Sequencer and state; everything but out_valid holds on idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      n         <= '0;
      k         <= '0;
      seg       <= '0;
      acc       <= '0;
      ins       <= '0;
      q         <= 1'b0;
      hist      <= '0;
      smp       <= '0;
      pins_out  <= '0;
      out_valid <= 1'b0;
      frames    <= '0;
      debug     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (si_valid) begin
        acc   <= cur[ACC_W-1:0];
        hist  <= {hist[N-2:0], b};
        debug <= (idx_phase && last_seg) ? in_bit : b;
        if (frame_start) smp <= pins_in;
        if (last_seg) seg <= '0;
        else          seg <= seg + 1'b1;
        if (idx_phase && last_seg) begin
          ins <= {ins[K-2:0], in_bit};
          k   <= k + 1'b1;
        end
        if (mask_final) begin
          q <= half;
          k <= '0;
          n <= (n == N_W'(N - 1)) ? '0 : n + 1'b1;
        end
        if (frame_end) begin
          pins_out  <= tap;
          out_valid <= 1'b1;
          frames    <= frames + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_s4ga_stream.sv
// Scoreboard bench for s4ga_stream at N=11 K=3 I=2 O=4 SI_W=4 FC_W=4 (LL=5).
module tb_s4ga_stream;

  localparam int unsigned N    = 11;
  localparam int unsigned K    = 3;
  localparam int unsigned I    = 2;
  localparam int unsigned O    = 4;
  localparam int unsigned SI_W = 4;
  localparam int unsigned FC_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [SI_W-1:0] si;
  logic            si_valid;
  logic [I-1:0]    pins_in;
  logic [O-1:0]    pins_out;
  logic            out_valid;
  logic [FC_W-1:0] frames;
  logic            debug;

  always #5 clk = ~clk;

  s4ga_stream #(.N(N), .K(K), .I(I), .O(O), .SI_W(SI_W), .FC_W(FC_W)) dut (
    .clk(clk), .rst(rst), .si(si), .si_valid(si_valid), .pins_in(pins_in),
    .pins_out(pins_out), .out_valid(out_valid), .frames(frames), .debug(debug)
  );

  int checks   = 0;
  int passes   = 0;
  int ov_count = 0;
  logic [7:0] fq[$];   // {pins_out, frames} per completed frame
  logic       dq[$];   // debug value per accepted beat, when tracked
  logic [3:0] exp_frames;
  bit         stall_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops expectations whenever the DUT presents results
  initial begin : monitor
    logic       acc;
    logic [7:0] e;
    logic       ed;
    forever begin
      @(posedge clk);
      acc = si_valid && !rst;
      #1;
      if (out_valid === 1'b1) begin
        ov_count++;
        if (fq.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
        else begin
          e = fq.pop_front();
          check("pins_out", pins_out, e[7:4]);
          check("frames", frames, e[3:0]);
        end
      end
      if (acc && dq.size() > 0) begin
        ed = dq.pop_front();
        check("debug", debug, ed);
      end
    end
  end

  task automatic beat(input logic [3:0] v, input bit has_dbg, input logic dbg);
    @(negedge clk);
    while (stall_en && $urandom_range(0, 1) == 1) begin
      si_valid = 1'b0;
      si = 4'($urandom);
      @(negedge clk);
    end
    if (has_dbg) dq.push_back(dbg);
    si = v;
    si_valid = 1'b1;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      si_valid = 1'b0;
    end
  endtask

  task automatic record(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [7:0] m, input bit has_dbg, input logic [4:0] d);
    beat(a, has_dbg, d[4]);
    beat(b, has_dbg, d[3]);
    beat(c, has_dbg, d[2]);
    beat(m[7:4], has_dbg, d[1]);
    beat(m[3:0], has_dbg, d[0]);
  endtask

  task automatic expect_frame(input logic [3:0] p);
    exp_frames = exp_frames + 4'd1;
    fq.push_back({p, exp_frames});
  endtask

  task automatic frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [7:0] m, input logic [3:0] p, input bit toggle);
    expect_frame(p);
    for (int r = 0; r < int'(N); r++) begin
      if (toggle && r == 4) pins_in[0] = ~pins_in[0];
      record(a, b, c, m, 1'b0, 5'b0);
    end
  endtask

  // rst is held with si_valid high to show reset wins
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    si_valid = 1'b1;
    si = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    si_valid = 1'b0;
    exp_frames = '0;
  endtask

  initial begin
    rst = 1'b0; si_valid = 1'b0; si = '0; pins_in = '0; stall_en = 0; exp_frames = '0;

    // 1: reset state
    do_reset();
    check("reset_pins_out", pins_out, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_frames", frames, 0);
    check("reset_debug", debug, 0);

    // 2: all-ones LUTs, continuous stream
    frame(4'hF, 4'hF, 4'hF, 8'h80, 4'hF, 0);
    @(posedge clk); #1;
    check("t2_out_valid_latency", out_valid, 1);
    idle(3);
    check("t2_out_valid_pulse", out_valid, 0);
    check("t2_frames", frames, 1);

    // 3: same stream with random stalls
    do_reset();
    ov_count = 0;
    stall_en = 1;
    frame(4'hF, 4'hF, 4'hF, 8'h80, 4'hF, 0);
    stall_en = 0;
    idle(4);
    check("t3_out_valid_count", ov_count, 1);
    check("t3_frames", frames, 1);

    // 4: frame-coherent input sampling
    do_reset();
    pins_in = 2'b01;
    frame(4'd11, 4'hF, 4'hF, 8'h80, 4'hF, 1);
    pins_in = 2'b00;
    frame(4'd11, 4'hF, 4'hF, 8'h80, 4'h0, 1);
    idle(3);
    check("t4_frames", frames, 2);

    // 5: constants, q path, history chain (each later LUT inverts the previous one)
    do_reset();
    expect_frame(4'hA);
    record(4'hF, 4'hE, 4'hF, 8'h20, 1'b1, 5'b10101);
    record(4'hF, 4'hD, 4'hF, 8'h20, 1'b1, 5'b10101);
    for (int r = 2; r < int'(N); r++) record(4'h0, 4'hF, 4'hF, 8'h08, 1'b0, 5'b0);
    idle(3);

    // 6: reset mid-frame discards the partial frame
    do_reset();
    for (int r = 0; r < 4; r++) record(4'hF, 4'hF, 4'hF, 8'h80, 1'b0, 5'b0);
    do_reset();
    ov_count = 0;
    frame(4'hF, 4'hF, 4'hF, 8'h80, 4'hF, 0);
    @(posedge clk); #1;
    check("t6_out_valid_latency", out_valid, 1);
    idle(4);
    check("t6_out_valid_count", ov_count, 1);
    check("t6_frames", frames, 1);

    // 7: frame counter wrap
    do_reset();
    repeat (16) frame(4'hF, 4'hF, 4'hF, 8'h80, 4'hF, 0);
    idle(3);
    check("t7_frames_wrap", frames, 0);

    idle(5);
    check("frames_drained", fq.size(), 0);
    check("debug_drained", dq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
